// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The arbiter connects to the slave modport; whoever drives the requests uses master.
interface rr_arbiter4_if;
    logic       EN;
    logic [3:0] R;
    logic [3:0] G;
    logic [1:0] Q;
    logic       V;

    modport master (
        output EN,
        output R,
        input  G,
        input  Q,
        input  V
    );

    modport slave (
        input  EN,
        input  R,
        output G,
        output Q,
        output V
    );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: holds a grant for at most MAX_HOLD cycles, then leaves a one-cycle gap.
// Grant is registered on the edge that samples the request; EN low revokes the grant, with no other backpressure.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter4_if.slave  bus
);

    localparam int            CW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q,   ptr_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [3:0]    g_q,     g_d;
    logic [1:0]    idx_q,   idx_d;
    logic          v_q,     v_d;

    logic          found;
    logic [1:0]    sel;
    logic [1:0]    cand;

    // Scan requesters starting at the pointer; the 2-bit add wraps past 3.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        cand  = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && bus.R[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        g_d     = g_q;
        idx_d   = idx_q;
        v_d     = v_q;
        case (state_q)
            IDLE: begin
                if (bus.EN && found) begin
                    state_d = GRANT;
                    g_d     = 4'b0001 << sel;
                    idx_d   = sel;
                    v_d     = 1'b1;
                    cnt_d   = '0;
                end else begin
                    g_d     = 4'b0000;
                    idx_d   = 2'b00;
                    v_d     = 1'b0;
                end
            end
            GRANT: begin
                if (!bus.R[idx_q] || !bus.EN || (cnt_q == HOLD_LAST)) begin
                    state_d = IDLE;
                    ptr_d   = idx_q + 2'd1;
                    g_d     = 4'b0000;
                    idx_d   = 2'b00;
                    v_d     = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'b00;
            cnt_q   <= '0;
            g_q     <= 4'b0000;
            idx_q   <= 2'b00;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            idx_q   <= idx_d;
            v_q     <= v_d;
        end
    end

    assign bus.G = g_q;
    assign bus.Q = idx_q;
    assign bus.V = v_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: two instances (MAX_HOLD 8 and 1) share stimulus and are tracked by
// an owner/held-cycles model; directed sequences add literal expectations.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] r;
    logic       cmp_en = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rr_arbiter4_if bus8 ();
    rr_arbiter4_if bus1 ();

    assign bus8.EN = en;
    assign bus8.R  = r;
    assign bus1.EN = en;
    assign bus1.R  = r;

    rr_arbiter4 #(.MAX_HOLD(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    rr_arbiter4 #(.MAX_HOLD(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    // Model: who owns the resource, for how many cycles so far, and whose turn is first.
    int m_owner [2] = '{-1, -1};
    int m_held  [2] = '{0, 0};
    int m_ptr   [2] = '{0, 0};
    int m_limit [2] = '{8, 1};

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_owner[d] = -1;
                m_held[d]  = 0;
                m_ptr[d]   = 0;
            end else if (m_owner[d] >= 0) begin
                if (!r[m_owner[d]] || !en || m_held[d] == m_limit[d]) begin
                    m_ptr[d]   = (m_owner[d] + 1) % 4;
                    m_owner[d] = -1;
                    m_held[d]  = 0;
                end else begin
                    m_held[d]  = m_held[d] + 1;
                end
            end else if (en && r != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    if (m_owner[d] < 0 && r[(m_ptr[d] + k) % 4]) begin
                        m_owner[d] = (m_ptr[d] + k) % 4;
                        m_held[d]  = 1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                logic [3:0] eg;
                logic [1:0] eq;
                logic       ev;
                eg = (m_owner[d] >= 0) ? (4'b0001 << m_owner[d]) : 4'b0000;
                eq = (m_owner[d] >= 0) ? 2'(m_owner[d]) : 2'b00;
                ev = (m_owner[d] >= 0);
                if (d == 0) begin
                    check("model_G_h8", {28'd0, bus8.G}, {28'd0, eg});
                    check("model_Q_h8", {30'd0, bus8.Q}, {30'd0, eq});
                    check("model_V_h8", {31'd0, bus8.V}, {31'd0, ev});
                end else begin
                    check("model_G_h1", {28'd0, bus1.G}, {28'd0, eg});
                    check("model_Q_h1", {30'd0, bus1.Q}, {30'd0, eq});
                    check("model_V_h1", {31'd0, bus1.V}, {31'd0, ev});
                end
            end
        end
    end

    // Apply inputs for one rising edge; returns at the following falling edge.
    task automatic cyc(input logic e, input logic [3:0] rr, input logic rn);
        en    = e;
        r     = rr;
        rst_n = rn;
        @(negedge clk);
    endtask

    task automatic expect8(input string name, input logic [3:0] g, input logic [1:0] q, input logic v);
        check({name, "_G"}, {28'd0, bus8.G}, {28'd0, g});
        check({name, "_Q"}, {30'd0, bus8.Q}, {30'd0, q});
        check({name, "_V"}, {31'd0, bus8.V}, {31'd0, v});
    endtask

    task automatic expect1(input string name, input logic [3:0] g, input logic [1:0] q, input logic v);
        check({name, "_G"}, {28'd0, bus1.G}, {28'd0, g});
        check({name, "_Q"}, {30'd0, bus1.Q}, {30'd0, q});
        check({name, "_V"}, {31'd0, bus1.V}, {31'd0, v});
    endtask

    initial begin
        en    = 1'b0;
        r     = 4'b0000;
        rst_n = 1'b0;
        @(negedge clk);
        cyc(1'b1, 4'b1111, 1'b0);
        cmp_en = 1'b1;
        expect8("reset_h8", 4'b0000, 2'b00, 1'b0);
        expect1("reset_h1", 4'b0000, 2'b00, 1'b0);

        // Full rotation with everyone requesting: 8-cycle grants, single gap between them.
        for (int k = 0; k < 5; k++) begin
            for (int h = 0; h < 8; h++) begin
                cyc(1'b1, 4'b1111, 1'b1);
                expect8("rotate_hold", 4'b0001 << (k % 4), 2'(k % 4), 1'b1);
            end
            cyc(1'b1, 4'b1111, 1'b1);
            expect8("rotate_gap", 4'b0000, 2'b00, 1'b0);
        end

        // Single requester dropping its request after three cycles.
        cyc(1'b0, 4'b0000, 1'b0);
        for (int h = 0; h < 3; h++) begin
            cyc(1'b1, 4'b0100, 1'b1);
            expect8("drop_hold", 4'b0100, 2'b10, 1'b1);
        end
        cyc(1'b1, 4'b0000, 1'b1);
        expect8("drop_release", 4'b0000, 2'b00, 1'b0);
        cyc(1'b1, 4'b0000, 1'b1);
        expect8("drop_idle", 4'b0000, 2'b00, 1'b0);
        cyc(1'b1, 4'b1111, 1'b1);
        expect8("drop_next_p3", 4'b1000, 2'b11, 1'b1);

        // EN low revokes requester 1; pointer moves to 2 and wraps to 0.
        cyc(1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0010, 1'b1);
        expect8("en_grant1", 4'b0010, 2'b01, 1'b1);
        cyc(1'b0, 4'b0010, 1'b1);
        expect8("en_revoke", 4'b0000, 2'b00, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1);
        expect8("en_low_idle", 4'b0000, 2'b00, 1'b0);
        cyc(1'b1, 4'b0011, 1'b1);
        expect8("en_wrap", 4'b0001, 2'b00, 1'b1);

        // Reset in the middle of a grant to requester 2 does not advance the pointer.
        cyc(1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0100, 1'b1);
        expect8("rst_grant2", 4'b0100, 2'b10, 1'b1);
        cyc(1'b1, 4'b0100, 1'b0);
        expect8("rst_revoke", 4'b0000, 2'b00, 1'b0);
        cyc(1'b1, 4'b1111, 1'b1);
        expect8("rst_p0", 4'b0001, 2'b00, 1'b1);

        // Single-cycle hold instance alternates between requesters 1 and 3.
        cyc(1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 4'b1010, 1'b1);
        expect1("h1_a", 4'b0010, 2'b01, 1'b1);
        cyc(1'b1, 4'b1010, 1'b1);
        expect1("h1_gap1", 4'b0000, 2'b00, 1'b0);
        cyc(1'b1, 4'b1010, 1'b1);
        expect1("h1_b", 4'b1000, 2'b11, 1'b1);
        cyc(1'b1, 4'b1010, 1'b1);
        expect1("h1_gap2", 4'b0000, 2'b00, 1'b0);
        cyc(1'b1, 4'b1010, 1'b1);
        expect1("h1_c", 4'b0010, 2'b01, 1'b1);

        // Random traffic, checked every cycle against the model.
        for (int n = 0; n < 10000; n++) begin
            cyc(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 49) != 0));
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
